micro_sequencer: RTL and testbench

//   Stage-1 producer for the microinstruction pipeline: holds the microprogram

---
 rtl/micro_sequencer.sv | 95 +++++++++
 tb/tb_micro_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Stage-1 microsequencer: uPC, writable control store, next-address select,
// and a one-deep valid/ready issue register for the ALU/SH/C/T fields.
module micro_sequencer #(
  parameter int UADDR_W    = 6,
  parameter int RESET_ADDR = 0,
  parameter int NCOND      = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [NCOND-1:0]     cond_in,
  input  logic [UADDR_W-1:0]   dispatch_addr,
  input  logic                 store_we,
  input  logic [UADDR_W-1:0]   store_addr,
  input  logic [23+UADDR_W:0]  store_data,
  output logic [3:0]           ALU_out,
  output logic [1:0]           SH_out,
  output logic [5:0]           C_out,
  output logic [6:0]           T_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [UADDR_W-1:0]   upc
);

  localparam int DEPTH = 2 ** UADDR_W;

  localparam logic [1:0] NS_SEQ  = 2'b00;
  localparam logic [1:0] NS_JUMP = 2'b01;
  localparam logic [1:0] NS_BR   = 2'b10;
  localparam logic [1:0] NS_DISP = 2'b11;

  typedef struct packed {
    logic [3:0]         alu;
    logic [1:0]         sh;
    logic [5:0]         c;
    logic [6:0]         t;
    logic [1:0]         nsel;
    logic [2:0]         cond;
    logic [UADDR_W-1:0] addr;
  } uword_t;

  logic [23+UADDR_W:0] store [DEPTH];
  uword_t              word;
  logic [7:0]          cond_ext;
  logic [UADDR_W-1:0]  upc_inc;
  logic [UADDR_W-1:0]  next_upc;
  logic                advance;

  // Read is combinational, so a same-edge write is seen only by later fetches.
  assign word    = uword_t'(store[upc]);
  assign upc_inc = upc + UADDR_W'(1);
  assign advance = run & (~out_valid | out_ready);

  // Unimplemented condition selects read as zero, so such branches fall through.
  always_comb begin
    cond_ext             = '0;
    cond_ext[NCOND-1:0]  = cond_in;
  end

  always_comb begin
    next_upc = upc_inc;
    case (word.nsel)
      NS_SEQ:  next_upc = upc_inc;
      NS_JUMP: next_upc = word.addr;
      NS_BR:   next_upc = cond_ext[word.cond] ? word.addr : upc_inc;
      NS_DISP: next_upc = dispatch_addr;
      default: next_upc = upc_inc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (store_we) store[store_addr] <= store_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upc       <= UADDR_W'(RESET_ADDR);
      out_valid <= 1'b0;
      ALU_out   <= '0;
      SH_out    <= '0;
      C_out     <= '0;
      T_out     <= '0;
    end else if (advance) begin
      upc       <= next_upc;
      out_valid <= 1'b1;
      ALU_out   <= word.alu;
      SH_out    <= word.sh;
      C_out     <= word.c;
      T_out     <= word.t;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench: expected issued fields are queued at fetch time and popped
// by a monitor on every accepted output; uPC is checked after each advance.
module tb_micro_sequencer;
  localparam int UW = 6;
  localparam int SEQ = 0, JMP = 1, BR = 2, DSP = 3;

  logic          clock, reset_n, run, store_we, out_ready;
  logic [7:0]    cond_in;
  logic [UW-1:0] dispatch_addr, store_addr;
  logic [29:0]   store_data;
  logic [3:0]    ALU_out, ALU2;
  logic [1:0]    SH_out, SH2;
  logic [5:0]    C_out, C2;
  logic [6:0]    T_out, T2;
  logic          out_valid, valid2;
  logic [UW-1:0] upc, upc2;

  micro_sequencer #(.UADDR_W(UW), .RESET_ADDR(0), .NCOND(8)) u_dut (
    .clock(clock), .reset_n(reset_n), .run(run), .cond_in(cond_in),
    .dispatch_addr(dispatch_addr), .store_we(store_we), .store_addr(store_addr),
    .store_data(store_data), .ALU_out(ALU_out), .SH_out(SH_out), .C_out(C_out),
    .T_out(T_out), .out_valid(out_valid), .out_ready(out_ready), .upc(upc));

  // Same stimulus, only two condition flags: COND=2 must never be taken.
  micro_sequencer #(.UADDR_W(UW), .RESET_ADDR(0), .NCOND(2)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .run(run), .cond_in(cond_in[1:0]),
    .dispatch_addr(dispatch_addr), .store_we(store_we), .store_addr(store_addr),
    .store_data(store_data), .ALU_out(ALU2), .SH_out(SH2), .C_out(C2),
    .T_out(T2), .out_valid(valid2), .out_ready(out_ready), .upc(upc2));

  int n_vec = 0;
  int n_bad = 0;
  logic [18:0] sb[$];
  logic [29:0] model [64];
  int seq1 [14] = '{0, 1, 2, 3, 4, 5, 20, 5, 6, 7, 8, 40, 13, 63};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [29:0] mk(input int alu, input int ns, input int cnd, input int ad);
    return {4'(alu), 2'(alu % 4), 6'(alu * 3), 7'(alu + 100), 2'(ns), 3'(cnd), 6'(ad)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input logic [29:0] d);
    store_we = 1'b1; store_addr = UW'(a); store_data = d;
    tick();
    store_we = 1'b0;
    model[a] = d;
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL issue: unexpected word %h with empty queue", {ALU_out, SH_out, C_out, T_out});
      end else begin
        chk("issue_fields", {13'd0, ALU_out, SH_out, C_out, T_out}, {13'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    reset_n = 1'b0; run = 1'b0; out_ready = 1'b1; store_we = 1'b0;
    store_addr = '0; store_data = '0; cond_in = 8'b0000_0100; dispatch_addr = 6'd13;
    #2;
    chk("reset_valid", out_valid, 0);
    chk("reset_upc", upc, 0);

    wr(0, mk(1, SEQ, 0, 0));  wr(1, mk(2, SEQ, 0, 0));  wr(2, mk(3, SEQ, 0, 0));
    wr(3, mk(4, SEQ, 0, 0));  wr(4, mk(5, SEQ, 0, 0));  wr(5, mk(6, BR, 2, 20));
    wr(20, mk(9, JMP, 0, 5)); wr(6, mk(7, SEQ, 0, 0));  wr(7, mk(8, SEQ, 0, 0));
    wr(8, mk(10, JMP, 0, 40)); wr(40, mk(11, DSP, 0, 0)); wr(13, mk(12, JMP, 0, 63));
    wr(63, mk(13, SEQ, 0, 0));
    chk("reset_alu", ALU_out, 0);
    chk("reset_t", T_out, 0);

    foreach (seq1[i]) sb.push_back(model[seq1[i]][29:11]);
    reset_n = 1'b1; run = 1'b1;
    tick(); chk("first_upc", upc, 1); chk("first_valid", out_valid, 1);
    repeat (3) tick();
    chk("seq_upc", upc, 4);
    tick(); tick();
    chk("branch_taken", upc, 20);
    chk("branch_ncond2", upc2, 6);
    cond_in = 8'h00;
    tick(); chk("jump_back", upc, 5);
    tick(); chk("branch_not_taken", upc, 6);
    tick(); tick(); chk("pre_stall_upc", upc, 8);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_upc", upc, 8);
      chk("stall_valid", out_valid, 1);
      chk("stall_alu", ALU_out, 8);
      chk("stall_t", T_out, 108);
    end
    out_ready = 1'b1;
    tick(); chk("jump_upc", upc, 40);
    tick(); chk("dispatch_upc", upc, 13);
    tick(); chk("jump63_upc", upc, 63);
    tick(); chk("wrap_upc", upc, 0);
    run = 1'b0;
    tick(); chk("run0_valid", out_valid, 0); chk("run0_upc", upc, 0);

    // Write collides with fetch at upc=0: old word issues, new one on revisit.
    wr(1, mk(15, JMP, 0, 0));
    store_we = 1'b1; store_addr = 6'd0; store_data = mk(14, SEQ, 0, 0); run = 1'b1;
    sb.push_back(model[0][29:11]);
    tick();
    store_we = 1'b0; model[0] = store_data;
    chk("coll_upc", upc, 1);
    sb.push_back(model[1][29:11]);
    tick(); chk("coll_jump_upc", upc, 0);
    sb.push_back(model[0][29:11]);
    tick(); chk("coll_revisit_upc", upc, 1);
    out_ready = 1'b0; run = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_upc", upc, 0);
    chk("async_rst_alu", ALU_out, 0);
    sb.delete();
    tick();
    reset_n = 1'b1; run = 1'b1; out_ready = 1'b1;
    sb.push_back(model[0][29:11]);
    tick(); chk("post_rst_upc", upc, 1);
    run = 1'b0;
    tick(); chk("post_rst_drain", out_valid, 0);
    tick();
    chk("queue_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
